mux_focus_scheduler: RTL and testbench

- Controller that shares one output data bus among NUM_SRC data sources by sequencing which source is "in focus".
- Focus advances round-robin on a debounced push of the toggle button (manual mode) or on a dwell-timer expiry (auto mode).
- Sources that are not valid are skipped.
- Sits between the board buttons/switches and the display datapath; replaces free-running focus toggling with a controlled, user-driven one.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_focus_scheduler_if.sv | 26 ++
 rtl/button_debouncer.sv | 67 ++++++
 rtl/mux_focus_scheduler.sv | 147 ++++++++++++++
 tb/tb_mux_focus_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the focus scheduler: FSM encoding and default
// configuration constants.
package mux_pkg;

    typedef enum logic {
        NO_SRC = 1'b0,
        HOLD   = 1'b1
    } state_e;

    localparam int DATABUS_WIDTH   = 9;
    localparam int NUM_SRC         = 4;
    localparam int SEL_WIDTH       = 2;
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int DWELL_CYCLES    = 8;

endpackage

// File: rtl/mux_focus_scheduler_if.sv
// Bundle of the source/button inputs and focus/data outputs of the scheduler.
// The board side is the master, the scheduler is the slave.
interface mux_focus_scheduler_if #(
    parameter int DATABUS_WIDTH = mux_pkg::DATABUS_WIDTH,
    parameter int NUM_SRC       = mux_pkg::NUM_SRC,
    parameter int SEL_WIDTH     = mux_pkg::SEL_WIDTH
);
    logic                               toggleButton;
    logic                               autoMode;
    logic [NUM_SRC-1:0]                 srcValid;
    logic [NUM_SRC*DATABUS_WIDTH-1:0]   dataIn;
    logic [DATABUS_WIDTH-1:0]           dataOut;
    logic [SEL_WIDTH-1:0]               focus;
    logic                               focusChanged;
    logic                               noSource;

    modport master (
        output toggleButton, autoMode, srcValid, dataIn,
        input  dataOut, focus, focusChanged, noSource
    );

    modport slave (
        input  toggleButton, autoMode, srcValid, dataIn,
        output dataOut, focus, focusChanged, noSource
    );
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw push button; emits a one-cycle press pulse
// on the rising edge of the debounced level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = mux_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       fill_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             armed_r;

    // Two-flop synchronizer plus a fill marker telling when sync2_r holds real data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            fill_r  <= 2'b00;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
            fill_r  <= {fill_r[0], 1'b1};
        end
    end

    // Stability counter; the debounced level flips after enough differing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= '0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                level_r <= ~level_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // A button held through reset must be seen released before a press counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r <= 1'b0;
        end else if (fill_r[1] && !sync2_r) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    assign press = level_r & ~level_d_r & armed_r;

endmodule

// File: rtl/mux_focus_scheduler.sv
// Shares one output bus among NUM_SRC sources; focus advances round-robin over
// valid sources on a debounced button press or on dwell expiry in auto mode.
module mux_focus_scheduler #(
    parameter int DATABUS_WIDTH   = mux_pkg::DATABUS_WIDTH,
    parameter int NUM_SRC         = mux_pkg::NUM_SRC,
    parameter int SEL_WIDTH       = mux_pkg::SEL_WIDTH,
    parameter int DEBOUNCE_CYCLES = mux_pkg::DEBOUNCE_CYCLES,
    parameter int DWELL_CYCLES    = mux_pkg::DWELL_CYCLES
) (
    input logic                  clk,
    input logic                  rst,
    mux_focus_scheduler_if.slave bus
);
    import mux_pkg::*;

    localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [SEL_WIDTH-1:0]     focus_r;
    logic [SEL_WIDTH-1:0]     focus_nxt_s;
    logic [SEL_WIDTH-1:0]     next_s;
    logic [SEL_WIDTH-1:0]     lowest_s;
    logic [DWELL_W-1:0]       dwell_r;
    logic [DATABUS_WIDTH-1:0] data_out_r;
    logic                     focus_changed_r;
    logic                     press_s;
    logic                     any_s;
    logic                     focus_valid_s;
    logic                     expire_s;
    logic                     adv_req_s;
    logic                     upd_s;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .button (bus.toggleButton),
        .press  (press_s)
    );

    assign any_s         = |bus.srcValid;
    assign focus_valid_s = bus.srcValid[focus_r];
    assign expire_s      = (dwell_r == DWELL_LAST);
    assign adv_req_s     = press_s | (bus.autoMode & expire_s);

    // Lowest-index valid source, used when leaving NO_SRC.
    always_comb begin
        lowest_s = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            lowest_s = bus.srcValid[i] ? SEL_WIDTH'(i) : lowest_s;
        end
    end

    // Round-robin search after focus; nearest valid candidate is assigned last.
    always_comb begin
        next_s = focus_r;
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
            next_s = bus.srcValid[(int'(focus_r) + k) % NUM_SRC]
                   ? SEL_WIDTH'((int'(focus_r) + k) % NUM_SRC) : next_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= NO_SRC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            NO_SRC:  state_nxt_s = any_s ? HOLD : NO_SRC;
            HOLD:    state_nxt_s = any_s ? HOLD : NO_SRC;
            default: state_nxt_s = NO_SRC;
        endcase
    end

    // FSM output logic: next focus value and whether an advance is taken.
    always_comb begin
        focus_nxt_s = focus_r;
        upd_s       = 1'b0;
        case (state_r)
            NO_SRC: begin
                if (any_s) begin
                    focus_nxt_s = lowest_s;
                end else begin
                    focus_nxt_s = focus_r;
                end
            end
            HOLD: begin
                if (!any_s) begin
                    focus_nxt_s = focus_r;
                end else if (!focus_valid_s || adv_req_s) begin
                    focus_nxt_s = next_s;
                    upd_s       = 1'b1;
                end else begin
                    focus_nxt_s = focus_r;
                end
            end
            default: begin
                focus_nxt_s = '0;
                upd_s       = 1'b0;
            end
        endcase
    end

    // Focus, change pulse and output data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            focus_r         <= '0;
            focus_changed_r <= 1'b0;
            data_out_r      <= '0;
        end else begin
            focus_r         <= focus_nxt_s;
            focus_changed_r <= (focus_nxt_s != focus_r);
            if (state_r == NO_SRC) begin
                data_out_r <= '0;
            end else begin
                data_out_r <= bus.dataIn[int'(focus_r)*DATABUS_WIDTH +: DATABUS_WIDTH];
            end
        end
    end

    // Dwell timer; any advance restarts it so each source gets a full dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_r <= '0;
        end else if ((state_r != HOLD) || !bus.autoMode || upd_s || expire_s) begin
            dwell_r <= '0;
        end else begin
            dwell_r <= dwell_r + DWELL_W'(1);
        end
    end

    assign bus.focus        = focus_r;
    assign bus.focusChanged = focus_changed_r;
    assign bus.dataOut      = data_out_r;
    assign bus.noSource     = (state_r == NO_SRC);

endmodule

// File: tb/tb_mux_focus_scheduler.sv
// Randomized bench for mux_focus_scheduler against a behavioural model of
// the focus rules (debounce, round-robin skip, dwell, reset behaviour).
module tb_mux_focus_scheduler;
    localparam int N     = 4;
    localparam int DW    = 9;
    localparam int SW    = 2;
    localparam int DEB   = 16;
    localparam int DWELL = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mux_focus_scheduler_if #(.DATABUS_WIDTH(DW), .NUM_SRC(N), .SEL_WIDTH(SW)) bus ();

    mux_focus_scheduler #(
        .DATABUS_WIDTH(DW), .NUM_SRC(N), .SEL_WIDTH(SW),
        .DEBOUNCE_CYCLES(DEB), .DWELL_CYCLES(DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    int   m_edges;
    bit   m_hold;
    int   m_focus;
    logic [DW-1:0] m_data;
    bit   m_chg;
    int   m_dwell;
    bit   m_db;
    bit   m_db_prev;
    bit   m_armed;
    int   m_run;
    bit   m_pipe[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic int rr_next(input int f, input logic [N-1:0] sv);
        for (int k = 1; k < N; k++) begin
            if (sv[(f + k) % N]) return (f + k) % N;
        end
        return f;
    endfunction

    function automatic int lowest(input logic [N-1:0] sv);
        for (int i = 0; i < N; i++) begin
            if (sv[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_edges = 0; m_hold = 1'b0; m_focus = 0; m_data = '0; m_chg = 1'b0;
        m_dwell = 0; m_db = 1'b0; m_db_prev = 1'b0; m_armed = 1'b0; m_run = 0;
        m_pipe = {};
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
    endtask

    // Predicts the state after the coming rising edge from the inputs held across it.
    task automatic model_step(input bit btn, input bit auto, input logic [N-1:0] sv,
                              input logic [N*DW-1:0] din);
        bit press, seen, expire, adv, upd, nh;
        int nf;
        press = m_db && !m_db_prev && m_armed;
        m_edges++;
        seen = m_pipe.pop_front();
        m_pipe.push_back(btn);
        m_db_prev = m_db;
        if (m_edges >= 3 && !seen) m_armed = 1'b1;
        if (seen != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db  = !m_db;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end

        expire = m_hold && auto && (m_dwell == DWELL - 1);
        adv    = press || expire;
        nf = m_focus; nh = m_hold; upd = 1'b0;
        if (!m_hold) begin
            if (sv != '0) begin nf = lowest(sv); nh = 1'b1; end
        end else if (sv == '0) begin
            nh = 1'b0;
        end else if (!sv[m_focus] || adv) begin
            nf = rr_next(m_focus, sv);
            upd = 1'b1;
        end
        m_data  = m_hold ? din[m_focus*DW +: DW] : '0;
        m_chg   = (nf != m_focus);
        m_dwell = (!m_hold || !auto || upd || expire) ? 0 : m_dwell + 1;
        m_focus = nf;
        m_hold  = nh;
    endtask

    task automatic check_all(input string pfx);
        check_val({pfx, "focus"},        32'(bus.focus),        32'(m_focus));
        check_val({pfx, "dataOut"},      32'(bus.dataOut),      32'(m_data));
        check_val({pfx, "focusChanged"}, 32'(bus.focusChanged), 32'(m_chg));
        check_val({pfx, "noSource"},     32'(bus.noSource),     32'(!m_hold));
    endtask

    // Called at a falling edge: check, drive new inputs, predict, wait one cycle.
    task automatic cycle(input bit btn, input bit auto, input logic [N-1:0] sv);
        logic [N*DW-1:0] din;
        check_all("");
        din = (N*DW)'({$urandom(), $urandom()});
        bus.toggleButton = btn;
        bus.autoMode     = auto;
        bus.srcValid     = sv;
        bus.dataIn       = din;
        model_step(btn, auto, sv, din);
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] pick_sv(input int sel);
        case (sel)
            0:       return 4'b0000;
            1:       return 4'b1111;
            2:       return 4'b1011;
            3:       return 4'b0110;
            4:       return 4'b0100;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Bouncy press inside a 90-cycle segment, or a quiet button.
    function automatic bit btn_at(input int c, input bit pressing);
        if (!pressing) return 1'b0;
        if (c < 10) return 1'($urandom_range(0, 1));
        if (c < 45) return 1'b1;
        if (c < 50) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    initial begin
        logic [N-1:0] sv;
        bit auto;
        bit pressing;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.toggleButton = 1'b0;
        bus.autoMode     = 1'b0;
        bus.srcValid     = '0;
        bus.dataIn       = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("init_");
        rst = 1'b1;

        // directed start: no sources, then all valid with source 0 = 0x055
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 4'b0000);
        for (int c = 0; c < 6; c++) begin
            check_all("");
            bus.srcValid = 4'b1111;
            bus.dataIn   = {9'h1aa, 9'h0f0, 9'h10f, 9'h055};
            model_step(1'b0, 1'b0, 4'b1111, {9'h1aa, 9'h0f0, 9'h10f, 9'h055});
            @(negedge clk);
        end

        for (int seg = 0; seg < 48; seg++) begin
            if (seg % 8 == 7) begin
                // button held, reset pulsed mid-count, held on after reset, then released
                for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0, 4'b1111);
                #2 rst = 1'b0;
                model_reset();
                #1 check_all("rst_");
                @(negedge clk);
                rst = 1'b1;
                for (int c = 0; c < 60; c++) cycle(1'b1, 1'b0, 4'b1111);
                for (int c = 0; c < 30; c++) cycle(1'b0, 1'b0, 4'b1111);
            end else begin
                sv       = pick_sv($urandom_range(0, 5));
                auto     = 1'($urandom_range(0, 1));
                pressing = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < 90; c++) begin
                    if (c == 60 && $urandom_range(0, 1) == 1) sv = pick_sv($urandom_range(0, 5));
                    cycle(btn_at(c, pressing), auto, sv);
                end
            end
        end

        check_all("final_");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
